// File: rtl/serial_mag_comp.sv
// serial_mag_comp: clocked digit-serial magnitude comparator.
// Compares two WIDTH-bit operands BPC bits per clock with a G/L comparator cell.
// The cell runs LSB-first (ripple, always N_STEPS steps) or MSB-first (stops at the
// first digit that resolves the order). Handshake: start/ready in, busy/done out.
// The results gt/lt/eq hold from DONE until the next accepted start.
// Optional build macro: SERIAL_CMP_SIGNED_EN adds the is_signed port, which selects a
// two's-complement compare by inverting the top bit of both latched operands.
module serial_mag_comp #(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             msb_first,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
`ifdef SERIAL_CMP_SIGNED_EN
    input  logic             is_signed,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    localparam int N_STEPS = WIDTH / BPC;
    localparam int SW      = $clog2(N_STEPS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] x_q, y_q;
    logic             msb_q;
    logic             g_q, l_q;
    logic [SW-1:0]    step_q;
    logic             busy_q, done_q, gt_q, lt_q, eq_q;

    logic             g_d, l_d;
    logic [WIDTH-1:0] x_in_s, y_in_s;
    logic             last_s;
    logic             exit_s;

    // Operand capture path: optional top-bit flip maps signed order onto unsigned order
    always_comb begin
        x_in_s = x;
        y_in_s = y;
`ifdef SERIAL_CMP_SIGNED_EN
        if (is_signed) begin
            x_in_s[WIDTH-1] = ~x[WIDTH-1];
            y_in_s[WIDTH-1] = ~y[WIDTH-1];
        end else begin
            x_in_s = x;
            y_in_s = y;
        end
`endif
    end

    // Comparator cell: fold the current digit's bits into G/L in mode order
    always_comb begin
        logic [WIDTH-1:0] xw;
        logic [WIDTH-1:0] yw;
        logic [BPC-1:0]   xd;
        logic [BPC-1:0]   yd;
        logic             xb;
        logic             yb;
        logic             gc;
        logic             lc;
        int               dig;
        dig = 0;
        if (step_q < SW'(N_STEPS)) begin
            if (msb_q) begin
                dig = N_STEPS - 1 - int'(step_q);
            end else begin
                dig = int'(step_q);
            end
        end else begin
            dig = 0;
        end
        xw = x_q >> (dig * BPC);
        yw = y_q >> (dig * BPC);
        xd = xw[BPC-1:0];
        yd = yw[BPC-1:0];
        gc = g_q;
        lc = l_q;
        for (int b = 0; b < BPC; b++) begin
            if (msb_q) begin
                // Top bit of the digit first; once resolved, the result is frozen
                xb = xd[BPC-1];
                yb = yd[BPC-1];
                xd = xd << 1;
                yd = yd << 1;
                if (gc | lc) begin
                    gc = gc;
                    lc = lc;
                end else begin
                    gc = xb & ~yb;
                    lc = ~xb & yb;
                end
            end else begin
                // Low bit first; a higher differing bit overrides the ripple result
                xb = xd[0];
                yb = yd[0];
                xd = xd >> 1;
                yd = yd >> 1;
                {gc, lc} = {(xb & ~yb) | (xb & gc & ~lc) | (~yb & gc & ~lc),
                            (~xb & yb) | (~xb & lc & ~gc) | (yb & lc & ~gc)};
            end
        end
        g_d = gc;
        l_d = lc;
    end

    assign last_s = (step_q == SW'(N_STEPS - 1));
    assign exit_s = last_s | (msb_q & (g_d | l_d));

    // Control FSM with operand/flag state and registered handshake/result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            msb_q   <= 1'b0;
            g_q     <= 1'b0;
            l_q     <= 1'b0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        x_q     <= x_in_s;
                        y_q     <= y_in_s;
                        msb_q   <= msb_first;
                        g_q     <= 1'b0;
                        l_q     <= 1'b0;
                        step_q  <= '0;
                        gt_q    <= 1'b0;
                        lt_q    <= 1'b0;
                        eq_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    g_q <= g_d;
                    l_q <= l_d;
                    if (step_q != SW'(N_STEPS)) begin
                        step_q <= step_q + SW'(1);
                    end
                    if (exit_s) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        gt_q    <= g_d;
                        lt_q    <= l_d;
                        eq_q    <= ~g_d & ~l_d;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ready = (state_q == S_IDLE);
    assign busy  = busy_q;
    assign done  = done_q;
    assign gt    = gt_q;
    assign lt    = lt_q;
    assign eq    = eq_q;

endmodule

// File: tb/tb_serial_mag_comp.sv
// Self-checking bench for serial_mag_comp: one WIDTH=8/BPC=1 instance and one
// WIDTH=8/BPC=4 instance. Directed table, handshake corner sequences, random sweep.
module tb_serial_mag_comp;

    logic       clk;
    logic       rst_n;
    logic       start, msb, sgn;
    logic [7:0] xa, ya;
    logic       ready, busy, done, gt, lt, eq;
    logic       start4, msb4, sgn4;
    logic [7:0] xa4, ya4;
    logic       ready4, busy4, done4, gt4, lt4, eq4;

    int errors = 0;
    int checks = 0;
    logic w4_sel = 1'b0;

    serial_mag_comp #(.WIDTH(8), .BPC(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .msb_first(msb), .x(xa), .y(ya),
`ifdef SERIAL_CMP_SIGNED_EN
        .is_signed(sgn),
`endif
        .ready(ready), .busy(busy), .done(done), .gt(gt), .lt(lt), .eq(eq));

    serial_mag_comp #(.WIDTH(8), .BPC(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .msb_first(msb4), .x(xa4), .y(ya4),
`ifdef SERIAL_CMP_SIGNED_EN
        .is_signed(sgn4),
`endif
        .ready(ready4), .busy(busy4), .done(done4), .gt(gt4), .lt(lt4), .eq(eq4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic s_done, s_busy, s_ready;
    logic [2:0] s_res;
    assign s_done  = w4_sel ? done4  : done;
    assign s_busy  = w4_sel ? busy4  : busy;
    assign s_ready = w4_sel ? ready4 : ready;
    assign s_res   = w4_sel ? {gt4, lt4, eq4} : {gt, lt, eq};

    typedef struct {
        logic [2:0] res;
        int         lat;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic       w4;
        logic [7:0] a;
        logic [7:0] b;
        logic       m;
        logic       s;
        logic [2:0] res;
        int         lat;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Independent reference: integer compare plus first-differing-digit latency
    function automatic void ref_model(input logic [7:0] a, input logic [7:0] b,
                                      input logic m, input logic s, input int bpc,
                                      output logic [2:0] res, output int lat);
        int n;
        logic [7:0] d;
        n = 8 / bpc;
        if (s) res = ($signed(a) > $signed(b)) ? 3'b100 : ($signed(a) < $signed(b)) ? 3'b010 : 3'b001;
        else   res = (a > b) ? 3'b100 : (a < b) ? 3'b010 : 3'b001;
        lat = n;
        if (m) begin
            for (int k = n - 1; k >= 0; k--) begin
                d = (a ^ b) >> (k * bpc);
                d = d & ((8'd1 << bpc) - 8'd1);
                if (d != 8'd0) begin
                    lat = n - k;
                    break;
                end
            end
        end
    endfunction

    task automatic run_cmp(input logic w4, input logic [7:0] a, input logic [7:0] b,
                           input logic m, input logic s, input logic [2:0] exp_res,
                           input int exp_lat, input string name, input bit pulse_mid);
        exp_t e;
        int lat;
        logic busy_bad;
        sb_q.push_back('{res: exp_res, lat: exp_lat});
        @(negedge clk);
        w4_sel = w4;
        if (w4) begin start4 = 1'b1; xa4 = a; ya4 = b; msb4 = m; sgn4 = s; end
        else    begin start  = 1'b1; xa  = a; ya  = b; msb  = m; sgn  = s; end
        @(posedge clk);
        #1;
        lat = 0;
        busy_bad = (s_busy != 1'b1);
        while (1) begin
            @(negedge clk);
            start4 = 1'b0;
            start  = 1'b0;
            if (pulse_mid && lat == 2) begin
                start = 1'b1; xa = 8'h00; ya = 8'hFF; msb = 1'b1;
            end
            @(posedge clk);
            #1;
            lat++;
            if (s_done) break;
            if (s_busy != 1'b1) busy_bad = 1'b1;
            if (lat > 40) begin
                chk({name, " timeout"}, lat, exp_lat);
                void'(sb_q.pop_front());
                return;
            end
        end
        if (s_busy != 1'b0) busy_bad = 1'b1;
        if (sb_q.size() == 0) begin
            chk({name, " scoreboard empty"}, 0, 1);
            return;
        end
        e = sb_q.pop_front();
        chk({name, " latency"}, lat, e.lat);
        chk({name, " result"}, int'(s_res), int'(e.res));
        chk({name, " busy"}, int'(busy_bad), 0);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk({name, " done_pulse/ready"}, int'({s_done, s_ready}), 1);
        chk({name, " held"}, int'(s_res), int'(e.res));
    endtask

    initial begin
        logic [2:0] rres;
        int rlat;
        logic [7:0] ra, rb;
        logic rm, rs;
        logic saw_done;

        rst_n = 1'b0;
        start = 1'b0; msb = 1'b0; sgn = 1'b0; xa = 8'h00; ya = 8'h00;
        start4 = 1'b0; msb4 = 1'b0; sgn4 = 1'b0; xa4 = 8'h00; ya4 = 8'h00;

        // Directed vectors: {w4, x, y, msb_first, is_signed, {gt,lt,eq}, latency}
        tbl.push_back('{1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0, 3'b001, 8});
        tbl.push_back('{1'b0, 8'h80, 8'h7F, 1'b1, 1'b0, 3'b100, 1});
        tbl.push_back('{1'b0, 8'h01, 8'h02, 1'b0, 1'b0, 3'b010, 8});
        tbl.push_back('{1'b0, 8'h01, 8'h02, 1'b1, 1'b0, 3'b010, 7});
        tbl.push_back('{1'b0, 8'h80, 8'h01, 1'b0, 1'b0, 3'b100, 8});
        tbl.push_back('{1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 3'b100, 1});
        tbl.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 3'b001, 8});
        tbl.push_back('{1'b0, 8'h10, 8'h11, 1'b1, 1'b0, 3'b010, 8});
        tbl.push_back('{1'b0, 8'h7F, 8'h80, 1'b0, 1'b0, 3'b010, 8});
        tbl.push_back('{1'b1, 8'h3C, 8'h3D, 1'b0, 1'b0, 3'b010, 2});
        tbl.push_back('{1'b1, 8'h3C, 8'h3D, 1'b1, 1'b0, 3'b010, 2});
        tbl.push_back('{1'b1, 8'h50, 8'h40, 1'b1, 1'b0, 3'b100, 1});
`ifdef SERIAL_CMP_SIGNED_EN
        tbl.push_back('{1'b0, 8'h80, 8'h01, 1'b0, 1'b1, 3'b010, 8});
        tbl.push_back('{1'b0, 8'h80, 8'h01, 1'b1, 1'b1, 3'b010, 1});
        tbl.push_back('{1'b1, 8'hFF, 8'h01, 1'b0, 1'b1, 3'b010, 2});
`endif

        #12;
        chk("reset outputs", int'({busy, done, gt, lt, eq, busy4, done4}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset ready", int'({ready, ready4}), 3);

        for (int i = 0; i < tbl.size(); i++) begin
            run_cmp(tbl[i].w4, tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].s,
                    tbl[i].res, tbl[i].lat, $sformatf("vec%0d", i), 1'b0);
        end

        // Start pulsed mid-run with different operands must be ignored
        run_cmp(1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0, 3'b001, 8, "start_while_busy", 1'b1);

        // Back-to-back: next accept on the edge right after DONE
        run_cmp(1'b0, 8'h80, 8'h7F, 1'b1, 1'b0, 3'b100, 1, "b2b_a", 1'b0);
        run_cmp(1'b0, 8'h01, 8'h02, 1'b1, 1'b0, 3'b010, 7, "b2b_b", 1'b0);

        // Reset during step 3 aborts the compare without a done pulse
        @(negedge clk);
        w4_sel = 1'b0;
        start = 1'b1; xa = 8'hA5; ya = 8'hA5; msb = 1'b0; sgn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort outputs", int'({busy, done, gt, lt, eq}), 0);
        chk("abort ready", int'(ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        chk("abort no done", int'(saw_done), 0);
        chk("abort idle ready", int'(ready), 1);

        // Random sweep against the reference model
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if (i % 4 == 0) rb = ra;
            rm = 1'($urandom_range(0, 1));
`ifdef SERIAL_CMP_SIGNED_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            if (i % 5 == 0) begin
                ref_model(ra, rb, rm, rs, 4, rres, rlat);
                run_cmp(1'b1, ra, rb, rm, rs, rres, rlat, "rand4", 1'b0);
            end else begin
                ref_model(ra, rb, rm, rs, 1, rres, rlat);
                run_cmp(1'b0, ra, rb, rm, rs, rres, rlat, "rand1", 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
